// File: rtl/keypad_pkg.sv
// keypad_pkg: shared definitions for the 4x4 keypad scanner.
//   state_t       scanner FSM states {SCAN, DEBOUNCE, HELD}
//   COL_RESET     column drive after reset (column 0 driven low)
//   key_map       (row index, column index) -> 4-bit hex key code
//   onehot4       true when exactly one bit of a 4-bit vector is set
//   onehot_index  bit position of a one-hot 4-bit vector
package keypad_pkg;

  typedef enum logic [1:0] {
    SCAN     = 2'd0,
    DEBOUNCE = 2'd1,
    HELD     = 2'd2
  } state_t;

  localparam logic [3:0] COL_RESET = 4'b1110;

  // Legend printed on the board keypad, row-major.
  function automatic logic [3:0] key_map(input logic [1:0] row_idx,
                                         input logic [1:0] col_idx);
    logic [3:0] code;
    case ({row_idx, col_idx})
      4'h0: code = 4'h1;
      4'h1: code = 4'h2;
      4'h2: code = 4'h3;
      4'h3: code = 4'hA;
      4'h4: code = 4'h4;
      4'h5: code = 4'h5;
      4'h6: code = 4'h6;
      4'h7: code = 4'hB;
      4'h8: code = 4'h7;
      4'h9: code = 4'h8;
      4'hA: code = 4'h9;
      4'hB: code = 4'hC;
      4'hC: code = 4'hE;
      4'hD: code = 4'h0;
      4'hE: code = 4'hF;
      default: code = 4'hD;
    endcase
    return code;
  endfunction

  function automatic logic onehot4(input logic [3:0] v);
    return (v != 4'd0) && ((v & (v - 4'd1)) == 4'd0);
  endfunction

  function automatic logic [1:0] onehot_index(input logic [3:0] v);
    logic [1:0] idx;
    idx = 2'd0;
    for (int i = 0; i < 4; i++) begin
      if (v[i]) idx = 2'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/keypad_sync.sv
// keypad_sync: 4-bit two-flop synchronizer for the raw keypad rows.
//   clk_i        system clock
//   rst_n_i      synchronous reset, active low; both stages reset to 4'b1111
//                (pulled-up rows, i.e. no key)
//   async_rows   raw active-low rows from the keypad
//   synced_rows  active-low rows, synchronized to clk_i
module keypad_sync (
  input  logic       clk_i,
  input  logic       rst_n_i,
  input  logic [3:0] async_rows,
  output logic [3:0] synced_rows
);

  logic [3:0] meta;

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      meta        <= 4'b1111;
      synced_rows <= 4'b1111;
    end else begin
      meta        <= async_rows;
      synced_rows <= meta;
    end
  end

endmodule

// File: rtl/keypad_scanner.sv
// keypad_scanner: scans a 4x4 keypad by driving columns one-cold, samples the
// pulled-up rows once per scan tick, debounces press and release, and reports
// a single held key.
//   clk_i           system clock
//   rst_n_i         synchronous reset, active low
//   kp_row_n_i      raw keypad rows, active low, asynchronous
//   kp_col_n_o      column drive, one-cold
//   keyboard_row_o  one-hot row of the held key, 0 when none
//   keyboard_col_o  one-hot column of the held key, 0 when none
//   key_code_o      hex code of the held key, 0 when none
//   key_pressed_o   high while a debounced key is held
//   key_valid_o     one-cycle pulse when a key is accepted
// Optional feature: define KEYPAD_AUTOREPEAT_EN to re-pulse key_valid_o every
// REPEAT_TICKS ticks while a key stays held.
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV       = 100000,
  parameter int DEBOUNCE_SCANS = 4,
  parameter int REPEAT_TICKS   = 250
) (
  input  logic       clk_i,
  input  logic       rst_n_i,
  input  logic [3:0] kp_row_n_i,
  output logic [3:0] kp_col_n_o,
  output logic [3:0] keyboard_row_o,
  output logic [3:0] keyboard_col_o,
  output logic [3:0] key_code_o,
  output logic       key_pressed_o,
  output logic       key_valid_o
);

  localparam int DIV_W = $clog2(SCAN_DIV);
  localparam int CNT_W = $clog2(DEBOUNCE_SCANS + 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_SCANS - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(DEBOUNCE_SCANS);

  state_t           state;
  state_t           next_state;
  logic [DIV_W-1:0] div_cnt;
  logic             tick;
  logic [3:0]       synced_n;
  logic [3:0]       rows;
  logic [3:0]       col_n;
  logic [3:0]       row_lat;
  logic [CNT_W-1:0] dbc;
  logic [CNT_W-1:0] rcnt;
  logic             advance_col;
  logic             latch_row;
  logic             accept;
  logic             release_key;
  logic             repeat_hit;

  keypad_sync u_sync (
    .clk_i       (clk_i),
    .rst_n_i     (rst_n_i),
    .async_rows  (kp_row_n_i),
    .synced_rows (synced_n)
  );

  assign rows       = ~synced_n;
  assign kp_col_n_o = col_n;
  assign tick       = (div_cnt == DIV_LAST);

  always_ff @(posedge clk_i) begin
    if (!rst_n_i)              div_cnt <= '0;
    else if (div_cnt == DIV_LAST) div_cnt <= '0;
    else                       div_cnt <= div_cnt + 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) state <= SCAN;
    else          state <= next_state;
  end

  // Multi-hot rows in SCAN are a ghosting/multi-key situation and simply
  // move on to the next column. The final debounce tick and the final release
  // tick both change state on that same tick edge, so the output registers
  // below update in the cycle right after the tick.
  always_comb begin
    next_state  = state;
    advance_col = 1'b0;
    latch_row   = 1'b0;
    accept      = 1'b0;
    release_key = 1'b0;
    case (state)
      SCAN: begin
        if (tick) begin
          if (onehot4(rows)) begin
            next_state = DEBOUNCE;
            latch_row  = 1'b1;
          end else begin
            advance_col = 1'b1;
          end
        end
      end
      DEBOUNCE: begin
        if (tick) begin
          if (rows == row_lat) begin
            if (dbc == CNT_LAST) begin
              next_state = HELD;
              accept     = 1'b1;
            end
          end else begin
            next_state  = SCAN;
            advance_col = 1'b1;
          end
        end
      end
      HELD: begin
        if (tick && (rows == 4'd0) && (rcnt == CNT_LAST)) begin
          next_state  = SCAN;
          release_key = 1'b1;
        end
      end
      default: next_state = SCAN;
    endcase
  end

  // Column drive rotates one-cold, so the held column is simply "not rotated".
  // Both debounce counters saturate at DEBOUNCE_SCANS.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      col_n   <= COL_RESET;
      row_lat <= 4'd0;
      dbc     <= '0;
      rcnt    <= '0;
    end else begin
      if (advance_col) col_n <= {col_n[2:0], col_n[3]};
      if (latch_row) begin
        row_lat <= rows;
        dbc     <= '0;
      end else if ((state == DEBOUNCE) && tick && (rows == row_lat) && (dbc != CNT_MAX)) begin
        dbc <= dbc + 1'b1;
      end
      if (accept) begin
        rcnt <= '0;
      end else if ((state == HELD) && tick) begin
        if (rows != 4'd0)        rcnt <= '0;
        else if (rcnt != CNT_MAX) rcnt <= rcnt + 1'b1;
      end
    end
  end

`ifdef KEYPAD_AUTOREPEAT_EN
  localparam int REP_W = $clog2(REPEAT_TICKS + 1);
  localparam logic [REP_W-1:0] REP_LAST = REP_W'(REPEAT_TICKS - 1);

  logic [REP_W-1:0] rep_cnt;

  // A release tick wins over a repeat on the same tick.
  assign repeat_hit = (state == HELD) && tick && !release_key && (rep_cnt == REP_LAST);

  always_ff @(posedge clk_i) begin
    if (!rst_n_i)     rep_cnt <= '0;
    else if (accept)  rep_cnt <= '0;
    else if ((state == HELD) && tick && !release_key)
      rep_cnt <= repeat_hit ? '0 : rep_cnt + 1'b1;
  end
`else
  logic repeat_unused;
  assign repeat_unused = (REPEAT_TICKS != 0);
  assign repeat_hit    = 1'b0;
`endif

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      keyboard_row_o <= 4'd0;
      keyboard_col_o <= 4'd0;
      key_code_o     <= 4'd0;
      key_pressed_o  <= 1'b0;
      key_valid_o    <= 1'b0;
    end else begin
      key_valid_o <= accept | repeat_hit;
      if (accept) begin
        keyboard_row_o <= row_lat;
        keyboard_col_o <= ~col_n;
        key_code_o     <= key_map(onehot_index(row_lat), onehot_index(~col_n));
        key_pressed_o  <= 1'b1;
      end else if (release_key) begin
        keyboard_row_o <= 4'd0;
        keyboard_col_o <= 4'd0;
        key_code_o     <= 4'd0;
        key_pressed_o  <= 1'b0;
      end
    end
  end

endmodule
